fixed_point_accumulator: RTL and testbench

FIXED_POINT_ACCUMULATOR -- requirements
Module: fixed_point_accumulator

---
 rtl/fixed_point_accumulator.sv | 92 +++++++++
 tb/tb_fixed_point_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_accumulator.sv
// Packet accumulator for signed fixed-point beats, with per-packet overflow flag.
// The sum can either saturate or wrap, and is held at the output until downstream accepts it.
module fixed_point_accumulator #(
    parameter int INTEGER_PART_WIDTH    = 2,
    parameter int FRACTIONAL_PART_WIDTH = 1,
    parameter int SATURATE              = 1,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUMBER_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUMBER_WIDTH-1:0] out_data,
    output logic                    out_overflow
);

    localparam logic [NUMBER_WIDTH-1:0] MAX_VAL = {1'b0, {(NUMBER_WIDTH-1){1'b1}}};
    localparam logic [NUMBER_WIDTH-1:0] MIN_VAL = {1'b1, {(NUMBER_WIDTH-1){1'b0}}};

    typedef enum logic {ACCUMULATE, OUTPUT} state_t;

    state_t                  state_q;
    logic [NUMBER_WIDTH-1:0] acc_q;
    logic                    ovfSticky_q;
    logic                    outValid_q;
    logic [NUMBER_WIDTH-1:0] outData_q;
    logic                    outOverflow_q;

    logic [NUMBER_WIDTH:0]   sumWide;
    logic                    addOvf;
    logic [NUMBER_WIDTH-1:0] sum_d;
    logic                    ovfSticky_d;

    // With sign-extended operands, overflow shows up as the top two bits disagreeing;
    // the top bit is then the true sign of the sum and picks the clamp direction.
    always_comb begin
        sumWide     = {acc_q[NUMBER_WIDTH-1], acc_q} + {in_data[NUMBER_WIDTH-1], in_data};
        addOvf      = sumWide[NUMBER_WIDTH] ^ sumWide[NUMBER_WIDTH-1];
        sum_d       = sumWide[NUMBER_WIDTH-1:0];
        if (addOvf && (SATURATE != 0)) begin
            sum_d = sumWide[NUMBER_WIDTH] ? MIN_VAL : MAX_VAL;
        end
        ovfSticky_d = ovfSticky_q | addOvf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ACCUMULATE;
            acc_q         <= '0;
            ovfSticky_q   <= 1'b0;
            outValid_q    <= 1'b0;
            outData_q     <= '0;
            outOverflow_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUMULATE: begin
                    if (in_valid) begin
                        if (in_last) begin
                            outData_q     <= sum_d;
                            outOverflow_q <= ovfSticky_d;
                            outValid_q    <= 1'b1;
                            state_q       <= OUTPUT;
                        end else begin
                            acc_q       <= sum_d;
                            ovfSticky_q <= ovfSticky_d;
                        end
                    end
                end
                OUTPUT: begin
                    // Accumulator is cleared only once the sum has been taken downstream.
                    if (out_ready) begin
                        acc_q       <= '0;
                        ovfSticky_q <= 1'b0;
                        outValid_q  <= 1'b0;
                        state_q     <= ACCUMULATE;
                    end
                end
                default: state_q <= ACCUMULATE;
            endcase
        end
    end

    assign in_ready     = (state_q == ACCUMULATE);
    assign out_valid    = outValid_q;
    assign out_data     = outData_q;
    assign out_overflow = outOverflow_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Directed bench driving a saturating and a wrapping accumulator side by side (3-bit data, raw -4..3).
// Inputs change on the falling edge; outputs are sampled on the falling edge or just after a reset change.
module tb_fixed_point_accumulator;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [W-1:0] inData;
    logic         inLast;
    logic         outReady;

    logic         satInReady, satOutValid, satOutOverflow;
    logic [W-1:0] satOutData;
    logic         wrapInReady, wrapOutValid, wrapOutOverflow;
    logic [W-1:0] wrapOutData;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] heldSat;
    logic [W-1:0] heldWrap;

    fixed_point_accumulator #(
        .INTEGER_PART_WIDTH(2), .FRACTIONAL_PART_WIDTH(1), .SATURATE(1)
    ) dutSat (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(satInReady), .in_data(inData), .in_last(inLast),
        .out_valid(satOutValid), .out_ready(outReady), .out_data(satOutData),
        .out_overflow(satOutOverflow)
    );

    fixed_point_accumulator #(
        .INTEGER_PART_WIDTH(2), .FRACTIONAL_PART_WIDTH(1), .SATURATE(0)
    ) dutWrap (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(wrapInReady), .in_data(inData), .in_last(inLast),
        .out_valid(wrapOutValid), .out_ready(outReady), .out_data(wrapOutData),
        .out_overflow(wrapOutOverflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Presents one beat at a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [W-1:0] data, input logic last);
        inValid = 1'b1;
        inData  = data;
        inLast  = last;
        @(negedge clk);
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic checkBoth(input string tag, input logic [W-1:0] expSat, input logic expSatOvf,
                             input logic [W-1:0] expWrap, input logic expWrapOvf);
        checkBit   ({tag, " sat valid"},  satOutValid,     1'b1);
        checkOutput({tag, " sat data"},   satOutData,      expSat);
        checkBit   ({tag, " sat ovf"},    satOutOverflow,  expSatOvf);
        checkBit   ({tag, " sat ready"},  satInReady,      1'b0);
        checkBit   ({tag, " wrap valid"}, wrapOutValid,    1'b1);
        checkOutput({tag, " wrap data"},  wrapOutData,     expWrap);
        checkBit   ({tag, " wrap ovf"},   wrapOutOverflow, expWrapOvf);
    endtask

    task automatic releaseOutput(input string tag);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkBit({tag, " released sat valid"},  satOutValid,  1'b0);
        checkBit({tag, " released sat ready"},  satInReady,   1'b1);
        checkBit({tag, " released wrap valid"}, wrapOutValid, 1'b0);
    endtask

    initial begin
        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b0;

        // Reset must take effect before the first rising edge at t=5.
        #2 rst = 1'b1;
        #1;
        checkBit   ("reset out_valid",    satOutValid,     1'b0);
        checkOutput("reset out_data",     satOutData,      3'b000);
        checkBit   ("reset out_overflow", satOutOverflow,  1'b0);
        checkBit   ("reset in_ready",     satInReady,      1'b1);
        checkOutput("reset wrap out_data", wrapOutData,    3'b000);
        checkBit   ("reset wrap in_ready", wrapInReady,    1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1 + 1 = 2 (1.0), no overflow; output held while out_ready is low.
        applyStimulus(3'b001, 1'b0);
        applyStimulus(3'b001, 1'b1);
        checkBoth("sum 1+1", 3'b010, 1'b0, 3'b010, 1'b0);
        @(negedge clk);
        checkBit   ("sum hold valid", satOutValid, 1'b1);
        checkBit   ("sum hold ready", satInReady,  1'b0);
        releaseOutput("sum");

        // 3 + 3: saturates to 3, wraps to 6 -> 3'b110 (-2).
        applyStimulus(3'b011, 1'b0);
        applyStimulus(3'b011, 1'b1);
        checkBoth("pos ovf 3+3", 3'b011, 1'b1, 3'b110, 1'b1);
        releaseOutput("pos ovf");

        // -4 + -1: saturates to -4, wraps to -5 -> 3'b011 (3).
        applyStimulus(3'b100, 1'b0);
        applyStimulus(3'b111, 1'b1);
        checkBoth("neg ovf -4-1", 3'b100, 1'b1, 3'b011, 1'b1);
        releaseOutput("neg ovf");

        // 3 + 1 - 3: sat 3 -> 0; wrap -4 -> 1. Flag sticks from the first add.
        applyStimulus(3'b011, 1'b0);
        applyStimulus(3'b001, 1'b0);
        applyStimulus(3'b101, 1'b1);
        checkBoth("sticky 3+1-3", 3'b000, 1'b1, 3'b001, 1'b1);
        releaseOutput("sticky");

        // Single beat passes through unchanged and the previous overflow has cleared.
        applyStimulus(3'b101, 1'b1);
        checkBoth("single -3", 3'b101, 1'b0, 3'b101, 1'b0);
        releaseOutput("single");

        // Backpressure: 1 + 2 = 3, held against noisy input traffic for five cycles.
        applyStimulus(3'b001, 1'b0);
        applyStimulus(3'b010, 1'b1);
        checkBoth("bp sum 1+2", 3'b011, 1'b0, 3'b011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            inValid = 1'b1;
            inData  = 3'($urandom_range(7, 0));
            inLast  = 1'($urandom_range(1, 0));
            @(negedge clk);
            checkOutput("bp held sat data",  satOutData,  3'b011);
            checkOutput("bp held wrap data", wrapOutData, 3'b011);
            checkBit   ("bp in_ready low",   satInReady,  1'b0);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        checkBit   ("bp released valid", satOutValid, 1'b0);
        checkBit   ("bp released ready", satInReady,  1'b1);
        checkOutput("bp retained data",  satOutData,  3'b011);
        applyStimulus(3'b010, 1'b1);
        checkBoth("bp next packet 2", 3'b010, 1'b0, 3'b010, 1'b0);
        releaseOutput("bp next");

        // Mid-packet reset throws away the partial sum of 2 + 1.
        applyStimulus(3'b010, 1'b0);
        applyStimulus(3'b001, 1'b0);
        rst     = 1'b1;
        inValid = 1'b1;
        inData  = 3'b011;
        inLast  = 1'b1;
        #1;
        checkOutput("midreset out_data", satOutData, 3'b000);
        checkBit   ("midreset in_ready", satInReady, 1'b1);
        @(negedge clk);
        rst     = 1'b0;
        inValid = 1'b0;
        inLast  = 1'b0;
        checkBit("midreset no accept", satOutValid, 1'b0);
        applyStimulus(3'b001, 1'b1);
        checkBoth("midreset 1", 3'b001, 1'b0, 3'b001, 1'b0);
        releaseOutput("midreset");

        // Reset while a sum is pending drops it without a handshake.
        applyStimulus(3'b011, 1'b0);
        applyStimulus(3'b011, 1'b1);
        heldSat  = satOutData;
        heldWrap = wrapOutData;
        checkOutput("pending sat data",  heldSat,  3'b011);
        checkOutput("pending wrap data", heldWrap, 3'b110);
        rst = 1'b1;
        #1;
        checkBit   ("outreset valid",    satOutValid,     1'b0);
        checkOutput("outreset data",     satOutData,      3'b000);
        checkBit   ("outreset ovf",      satOutOverflow,  1'b0);
        checkBit   ("outreset wrap ovf", wrapOutOverflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'b110, 1'b1);
        checkBoth("after outreset -2", 3'b110, 1'b0, 3'b110, 1'b0);
        releaseOutput("after outreset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
